pipe_ex_stage: RTL and testbench

Execute stage of the five-stage MIPS-style teaching pipeline. Holds the ID/EX pipeline register and the ALU, and drives the result, store data, destination register and control flags into the MEM stage. The ALU result is combinational from the ID/EX register so the ID stage can forward it in the same cycle. A 4-bit instruction tag (type, number) travels alongside each instruction for the LCD pipeline trace.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_ex_stage_if.sv | 44 ++++
 rtl/pipe_alu.sv | 37 +++
 rtl/pipe_ex_stage.sv | 78 +++++++
 tb/tb_pipe_ex_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: ALU operation codes and the ID/EX register layout.
// The ID stage uses the same aluc constants when it decodes instructions.
package pipe_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Everything the EX stage keeps from ID for one instruction.
    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] in_a;
        logic [31:0] in_b;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic        regrt;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

endpackage

// File: rtl/pipe_ex_stage_if.sv
// ID->EX->MEM signal bundle for the execute stage. The master side is the
// ID stage (plus MEM as the consumer of ex_*); the slave side is pipe_ex_stage.
interface pipe_ex_stage_if;
    logic [31:0] id_imm;
    logic [31:0] id_inA;
    logic [31:0] id_inB;
    logic        id_wreg;
    logic        id_m2reg;
    logic        id_wmem;
    logic [3:0]  id_aluc;
    logic        id_aluimm;
    logic        id_shift;
    logic        id_regrt;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [3:0]  ID_ins_type;
    logic [3:0]  ID_ins_number;

    logic        ex_wreg;
    logic        ex_m2reg;
    logic        ex_wmem;
    logic [31:0] ex_aluR;
    logic [31:0] ex_inB;
    logic [4:0]  ex_destR;
    logic        ex_zero;
    logic [3:0]  EX_ins_type;
    logic [3:0]  EX_ins_number;

    modport master (
        output id_imm, id_inA, id_inB, id_wreg, id_m2reg, id_wmem, id_aluc,
               id_aluimm, id_shift, id_regrt, id_rt, id_rd,
               ID_ins_type, ID_ins_number,
        input  ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR, ex_zero,
               EX_ins_type, EX_ins_number
    );

    modport slave (
        input  id_imm, id_inA, id_inB, id_wreg, id_m2reg, id_wmem, id_aluc,
               id_aluimm, id_shift, id_regrt, id_rt, id_rd,
               ID_ins_type, ID_ins_number,
        output ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR, ex_zero,
               EX_ins_type, EX_ins_number
    );
endinterface

// File: rtl/pipe_alu.sv
// Combinational 32-bit ALU of the execute stage. Low three aluc bits select
// the operation; aluc[3] only distinguishes arithmetic from logical right shift.
module pipe_alu
    import pipe_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  aluc_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    // Operation select; add/sub wrap modulo 2^32 with no overflow detection.
    always_comb begin
        result_o = 32'd0;
        case (aluc_i[2:0])
            ALU_ADD[2:0]: result_o = a_i + b_i;
            ALU_SUB[2:0]: result_o = a_i - b_i;
            ALU_AND[2:0]: result_o = a_i & b_i;
            ALU_OR[2:0]:  result_o = a_i | b_i;
            ALU_XOR[2:0]: result_o = a_i ^ b_i;
            ALU_LUI[2:0]: result_o = {b_i[15:0], 16'h0000};
            ALU_SLL[2:0]: result_o = b_i << a_i[4:0];
            ALU_SRL[2:0]: begin
                if (aluc_i[3]) begin
                    result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
                end else begin
                    result_o = b_i >> a_i[4:0];
                end
            end
            default:      result_o = 32'd0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/pipe_ex_stage.sv
// Execute stage: ID/EX pipeline register, operand/destination muxes and ALU.
// Define EX_TRACE_EN to keep the LCD trace tag flops; otherwise the EX tag is 0.
module pipe_ex_stage
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    pipe_ex_stage_if.slave   ex_if
);

    idex_t       idex_d;
    idex_t       idex_q;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;

    assign idex_d.imm    = ex_if.id_imm;
    assign idex_d.in_a   = ex_if.id_inA;
    assign idex_d.in_b   = ex_if.id_inB;
    assign idex_d.wreg   = ex_if.id_wreg;
    assign idex_d.m2reg  = ex_if.id_m2reg;
    assign idex_d.wmem   = ex_if.id_wmem;
    assign idex_d.aluc   = ex_if.id_aluc;
    assign idex_d.aluimm = ex_if.id_aluimm;
    assign idex_d.shift  = ex_if.id_shift;
    assign idex_d.regrt  = ex_if.id_regrt;
    assign idex_d.rt     = ex_if.id_rt;
    assign idex_d.rd     = ex_if.id_rd;

    // ID/EX register: free-running, bubbles come from ID as zeroed controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Shift amount comes from the instruction's sa field, imm[10:6].
    assign alu_a_s = idex_q.shift  ? {27'd0, idex_q.imm[10:6]} : idex_q.in_a;
    assign alu_b_s = idex_q.aluimm ? idex_q.imm : idex_q.in_b;

    pipe_alu u_alu (
        .a_i      (alu_a_s),
        .b_i      (alu_b_s),
        .aluc_i   (idex_q.aluc),
        .result_o (ex_if.ex_aluR),
        .zero_o   (ex_if.ex_zero)
    );

    assign ex_if.ex_wreg  = idex_q.wreg;
    assign ex_if.ex_m2reg = idex_q.m2reg;
    assign ex_if.ex_wmem  = idex_q.wmem;
    assign ex_if.ex_inB   = idex_q.in_b;
    assign ex_if.ex_destR = idex_q.regrt ? idex_q.rt : idex_q.rd;

`ifdef EX_TRACE_EN
    logic [3:0] ins_type_q;
    logic [3:0] ins_number_q;

    // Trace tag rides alongside the instruction for the LCD display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_type_q   <= 4'd0;
            ins_number_q <= 4'd0;
        end else begin
            ins_type_q   <= ex_if.ID_ins_type;
            ins_number_q <= ex_if.ID_ins_number;
        end
    end

    assign ex_if.EX_ins_type   = ins_type_q;
    assign ex_if.EX_ins_number = ins_number_q;
`else
    assign ex_if.EX_ins_type   = 4'd0;
    assign ex_if.EX_ins_number = 4'd0;
`endif

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Scoreboard bench for pipe_ex_stage: directed instructions push hand-computed
// expectations; a monitor pops and compares one edge after each presentation.
module tb_pipe_ex_stage;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipe_ex_stage_if bus ();

    pipe_ex_stage dut (
        .clk   (clk),
        .rst   (rst),
        .ex_if (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] alu_r;
        logic [31:0] in_b;
        logic [4:0]  dest_r;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  ty;
        logic [3:0]  num;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_aluR"},  bus.ex_aluR, 32'd0);
        chk({tag, "_zero"},  {31'd0, bus.ex_zero}, 32'd1);
        chk({tag, "_inB"},   bus.ex_inB, 32'd0);
        chk({tag, "_destR"}, {27'd0, bus.ex_destR}, 32'd0);
        chk({tag, "_ctl"},   {29'd0, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}, 32'd0);
        chk({tag, "_tag"},   {24'd0, bus.EX_ins_type, bus.EX_ins_number}, 32'd0);
    endtask

    task automatic drive(input logic [31:0] imm, input logic [31:0] in_a, input logic [31:0] in_b,
                         input logic [3:0] aluc, input logic aluimm, input logic shift,
                         input logic regrt, input logic [4:0] rt, input logic [4:0] rd,
                         input logic wreg, input logic m2reg, input logic wmem,
                         input logic [3:0] ty, input logic [3:0] num);
        bus.id_imm        = imm;
        bus.id_inA        = in_a;
        bus.id_inB        = in_b;
        bus.id_aluc       = aluc;
        bus.id_aluimm     = aluimm;
        bus.id_shift      = shift;
        bus.id_regrt      = regrt;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.id_wreg       = wreg;
        bus.id_m2reg      = m2reg;
        bus.id_wmem       = wmem;
        bus.ID_ins_type   = ty;
        bus.ID_ins_number = num;
    endtask

    // Present one instruction at the falling edge and queue its expected EX view.
    task automatic issue(input string name, input logic [31:0] imm, input logic [31:0] in_a,
                         input logic [31:0] in_b, input logic [3:0] aluc, input logic aluimm,
                         input logic shift, input logic regrt, input logic [4:0] rt,
                         input logic [4:0] rd, input logic wreg, input logic m2reg,
                         input logic wmem, input logic [3:0] ty, input logic [3:0] num,
                         input logic [31:0] exp_alu);
        exp_t e;
        @(negedge clk);
        drive(imm, in_a, in_b, aluc, aluimm, shift, regrt, rt, rd, wreg, m2reg, wmem, ty, num);
        e.name   = name;
        e.alu_r  = exp_alu;
        e.in_b   = in_b;
        e.dest_r = regrt ? rt : rd;
        e.wreg   = wreg;
        e.m2reg  = m2reg;
        e.wmem   = wmem;
`ifdef EX_TRACE_EN
        e.ty     = ty;
        e.num    = num;
`else
        e.ty     = 4'd0;
        e.num    = 4'd0;
`endif
        sb_q.push_back(e);
    endtask

    // Monitor: whatever was presented before this edge must now be in EX.
    always @(posedge clk) begin
        if (!rst && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            #1;
            chk({e.name, "_aluR"},  bus.ex_aluR, e.alu_r);
            chk({e.name, "_zero"},  {31'd0, bus.ex_zero}, {31'd0, (e.alu_r == 32'd0)});
            chk({e.name, "_inB"},   bus.ex_inB, e.in_b);
            chk({e.name, "_destR"}, {27'd0, bus.ex_destR}, {27'd0, e.dest_r});
            chk({e.name, "_ctl"},   {29'd0, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem},
                                    {29'd0, e.wreg, e.m2reg, e.wmem});
            chk({e.name, "_tag"},   {24'd0, bus.EX_ins_type, bus.EX_ins_number},
                                    {24'd0, e.ty, e.num});
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(32'h1234_5678, 32'hAAAA_5555, 32'h5555_AAAA, ALU_OR, 1'b1, 1'b0, 1'b1,
              5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 4'hA, 4'hB);
        #1;
        check_all_zero("reset0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // name          imm           inA           inB           aluc     ai   sh   rg   rt    rd   w    m    wm   ty    num   expected
        issue("add_wrap", 32'h0,       32'hFFFFFFFF, 32'h1,        ALU_ADD, 1'b0,1'b0,1'b0,5'd2, 5'd5,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'h0);
        issue("sub",      32'h0,       32'h5,        32'h7,        ALU_SUB, 1'b0,1'b0,1'b0,5'd2, 5'd6,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'hFFFFFFFE);
        issue("or_imm",   32'h0000FFF0,32'h10,       32'hDEADBEEF, ALU_OR,  1'b1,1'b0,1'b1,5'd9, 5'd3,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'h0000FFF0);
        issue("srl",      32'h00000100,32'h0,        32'h80000000, ALU_SRL, 1'b0,1'b1,1'b0,5'd1, 5'd4,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'h08000000);
        issue("sra",      32'h00000100,32'h0,        32'h80000000, ALU_SRA, 1'b0,1'b1,1'b0,5'd1, 5'd4,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'hF8000000);
        issue("sll",      32'h00000100,32'h0,        32'h1,        ALU_SLL, 1'b0,1'b1,1'b0,5'd1, 5'd4,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'h00000010);
        issue("sll_a40",  32'h0,       32'h24,       32'h1,        ALU_SLL, 1'b0,1'b0,1'b0,5'd1, 5'd4,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'h00000010);
        issue("lui",      32'h00001234,32'h0,        32'h0,        ALU_LUI, 1'b1,1'b0,1'b1,5'd10,5'd0,1'b1,1'b0,1'b0,4'h0, 4'h0, 32'h12340000);
        issue("b2b_add",  32'h0,       32'h3,        32'h4,        ALU_ADD, 1'b0,1'b0,1'b0,5'd0, 5'd11,1'b1,1'b0,1'b0,4'h1,4'h2, 32'h7);
        issue("b2b_xor",  32'h0,       32'h0000F0F0, 32'h00000FF0, ALU_XOR, 1'b0,1'b0,1'b1,5'd12,5'd13,1'b0,1'b0,1'b0,4'h2,4'h3, 32'h0000FF00);
        issue("and_st",   32'h0,       32'hFF,       32'h0F,       ALU_AND, 1'b0,1'b0,1'b1,5'd14,5'd0,1'b0,1'b1,1'b1,4'h3, 4'h4, 32'h0000000F);
        issue("bubble",   32'h0,       32'h0,        32'h0,        ALU_ADD, 1'b0,1'b0,1'b0,5'd0, 5'd0,1'b0,1'b0,1'b0,4'h0, 4'h0, 32'h0);
        issue("pre_rst",  32'h0,       32'h1,        32'h2,        ALU_ADD, 1'b0,1'b0,1'b0,5'd0, 5'd17,1'b1,1'b1,1'b0,4'h5,4'h6, 32'h3);

        // Asynchronous reset between edges with a live instruction in EX.
        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'h1357_9BDF, 32'h2468_ACE0, ALU_XOR, 1'b0, 1'b0, 1'b1,
              5'd31, 5'd30, 1'b1, 1'b1, 1'b1, 4'hF, 4'hE);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        issue("post_rst", 32'h0,       32'h9,        32'h4,        ALU_SUB, 1'b0,1'b0,1'b0,5'd0, 5'd21,1'b1,1'b0,1'b0,4'h7,4'h8, 32'h5);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
